// File: rtl/immediate_generator_pkg.sv
// Shared RISC-V decode constants: major opcodes, immediate format codes
// and the opcode-to-format mapping used by the immediate generator.
package immediate_generator_pkg;

   typedef logic [2:0] imm_fmt_t;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   localparam imm_fmt_t FMT_NONE = 3'd0;
   localparam imm_fmt_t FMT_I    = 3'd1;
   localparam imm_fmt_t FMT_S    = 3'd2;
   localparam imm_fmt_t FMT_B    = 3'd3;
   localparam imm_fmt_t FMT_U    = 3'd4;
   localparam imm_fmt_t FMT_J    = 3'd5;

   // Any opcode not listed (including compressed encodings with [1:0] != 11)
   // carries no immediate.
   function automatic imm_fmt_t opcode_to_fmt(input logic [6:0] opc);
      imm_fmt_t fmt;
      case (opc)
         OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32,
         OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
         OPC_STORE:                          fmt = FMT_S;
         OPC_BRANCH:                         fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                 fmt = FMT_U;
         OPC_JAL:                            fmt = FMT_J;
         default:                            fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/immediate_generator_imm_decode.sv
// Combinational immediate decode: picks the format from the opcode,
// assembles the scattered immediate bits and sign-extends to WIDTH.
module imm_decode
   import immediate_generator_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [31:0]      instruction,
   output logic [WIDTH-1:0] immediate,
   output logic [2:0]       imm_fmt
);

   logic [31:0] imm32;
   logic        sign;

   // Format select and per-format field assembly, already extended to 32 bits.
   always_comb begin
      imm_fmt = opcode_to_fmt(instruction[6:0]);
      imm32   = '0;
      case (imm_fmt)
         FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
         FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
         FMT_U: imm32 = {instruction[31:12], 12'b0};
         FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   // Every real format signs from instruction[31], so the upper datapath bits
   // are just that bit replicated; this also covers WIDTH=32 with no special case.
   always_comb begin
      sign             = (imm_fmt != FMT_NONE) & instruction[31];
      immediate        = {WIDTH{sign}};
      immediate[31:0]  = imm32;
   end

endmodule

// File: rtl/immediate_generator.sv
// Decode-stage immediate generator: combinational immediate/format for
// same-cycle use, plus a stallable, async-reset copy for the ID/EX boundary.
module immediate_generator
   import immediate_generator_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [31:0]      instruction,
   output logic [WIDTH-1:0] immediate,
   output logic [2:0]       imm_fmt,
   output logic [WIDTH-1:0] immediate_q,
   output logic [2:0]       imm_fmt_q
);

   imm_decode #(
      .WIDTH (WIDTH)
   ) u_imm_decode (
      .instruction (instruction),
      .immediate   (immediate),
      .imm_fmt     (imm_fmt)
   );

   // ID/EX register: clears to NONE/0 on reset, holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         immediate_q <= '0;
         imm_fmt_q   <= FMT_NONE;
      end else if (en) begin
         immediate_q <= immediate;
         imm_fmt_q   <= imm_fmt;
      end
   end

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [31:0] instruction;

   logic [63:0] immediate, immediate_q;
   logic [2:0]  imm_fmt, imm_fmt_q;
   logic [31:0] immediate32, immediate32_q;
   logic [2:0]  imm_fmt32, imm_fmt32_q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      int          kind;   // 0: comb W64, 1: registered W64, 2: comb W32
      string       name;
   } exp_t;

   exp_t sb[$];
   event sample_ev;

   always #5 clk = ~clk;

   immediate_generator #(.WIDTH(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .instruction (instruction),
      .immediate   (immediate),
      .imm_fmt     (imm_fmt),
      .immediate_q (immediate_q),
      .imm_fmt_q   (imm_fmt_q)
   );

   immediate_generator #(.WIDTH(32)) dut32 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .instruction (instruction),
      .immediate   (immediate32),
      .imm_fmt     (imm_fmt32),
      .immediate_q (immediate32_q),
      .imm_fmt_q   (imm_fmt32_q)
   );

   task automatic push(input int kind, input logic [63:0] imm, input logic [2:0] fmt,
                       input string name);
      exp_t e;
      e.imm  = imm;
      e.fmt  = fmt;
      e.kind = kind;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic sample();
      -> sample_ev;
      #1;
   endtask

   task automatic comb(input logic [31:0] ins, input logic [63:0] imm,
                       input logic [2:0] fmt, input string name);
      instruction = ins;
      #1;
      push(0, imm, fmt, name);
      sample();
   endtask

   task automatic comb32(input logic [31:0] ins, input logic [63:0] imm,
                         input logic [2:0] fmt, input string name);
      instruction = ins;
      #1;
      push(2, imm, fmt, name);
      sample();
   endtask

   task automatic load(input logic [31:0] ins, input logic [63:0] imm,
                       input logic [2:0] fmt, input string name);
      @(negedge clk);
      instruction = ins;
      en          = 1'b1;
      @(posedge clk);
      #1;
      push(1, imm, fmt, name);
      sample();
   endtask

   // Monitor: drains the scoreboard whenever the driver presents a sample point.
   exp_t        m_e;
   logic [63:0] m_imm;
   logic [2:0]  m_fmt;
   initial begin
      forever begin
         @(sample_ev);
         while (sb.size() > 0) begin
            m_e = sb.pop_front();
            case (m_e.kind)
               0:       begin m_imm = immediate;             m_fmt = imm_fmt;   end
               1:       begin m_imm = immediate_q;           m_fmt = imm_fmt_q; end
               default: begin m_imm = {32'b0, immediate32};  m_fmt = imm_fmt32; end
            endcase
            checks++;
            if (m_imm !== m_e.imm) begin
               errors++;
               $display("FAIL %s imm: got %h expected %h", m_e.name, m_imm, m_e.imm);
            end
            checks++;
            if (m_fmt !== m_e.fmt) begin
               errors++;
               $display("FAIL %s fmt: got %0d expected %0d", m_e.name, m_fmt, m_e.fmt);
            end
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   logic [31:0] stall_ins [3];

   initial begin
      rst_n       = 1'b0;
      en          = 1'b0;
      instruction = 32'h0;
      stall_ins[0] = 32'h0010006F;
      stall_ins[1] = 32'h800000B7;
      stall_ins[2] = 32'h0020A423;

      #2;
      push(1, 64'h0, 3'd0, "reset_q");
      sample();

      // combinational path works while held in reset
      comb(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "comb_in_reset");
      en = 1'b1;
      @(posedge clk);
      #1;
      push(1, 64'h0, 3'd0, "reset_hold_q");
      sample();
      @(negedge clk);
      rst_n = 1'b1;

      comb(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "addi_m1");
      comb(32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1, "addi_2047");
      comb(32'h03F09093, 64'h0000_0000_0000_003F, 3'd1, "slli_63");
      comb(32'h0010009B, 64'h0000_0000_0000_0001, 3'd1, "addiw_1");
      comb(32'h00008067, 64'h0000_0000_0000_0000, 3'd1, "jalr_ret");
      comb(32'hC0002573, 64'hFFFF_FFFF_FFFF_FC00, 3'd1, "csr_cycle");
      comb(32'h0020A423, 64'h0000_0000_0000_0008, 3'd2, "sw_8");
      comb(32'hFE20AFA3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, "sw_m1");
      comb(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, "beq_m4");
      comb(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, "lui_neg");
      comb(32'h12345097, 64'h0000_0000_1234_5000, 3'd4, "auipc_pos");
      comb(32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, "jal_2048");
      comb(32'hFFFFF06F, 64'hFFFF_FFFF_FFFF_FFFE, 3'd5, "jal_m2");
      comb(32'h002081B3, 64'h0, 3'd0, "add_none");
      comb(32'h00000000, 64'h0, 3'd0, "zero_none");
      comb(32'hFFFFFFF0, 64'h0, 3'd0, "compressed_none");
      comb(32'hFFFFFFFF, 64'h0, 3'd0, "opc_7f_none");

      comb32(32'h800000B7, 64'h0000_0000_8000_0000, 3'd4, "w32_lui_neg");
      comb32(32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 3'd1, "w32_addi_m1");
      comb32(32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, "w32_jal_2048");

      load(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "q_addi");

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en          = 1'b0;
         instruction = stall_ins[i];
         @(posedge clk);
         #1;
         push(1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, "q_stall");
         sample();
      end

      load(32'h0010006F, 64'h0000_0000_0000_0800, 3'd5, "q_jal");
      // between edges: clear must not wait for clk
      rst_n = 1'b0;
      #1;
      push(1, 64'h0, 3'd0, "q_async_rst");
      sample();
      rst_n = 1'b1;
      load(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, "q_after_rst");
      load(32'h0020A423, 64'h0000_0000_0000_0008, 3'd2, "q_sw");

      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
